// File: rtl/temperature_calculator.sv
// -----------------------------------------------------------------------------
// temperature_calculator
//
// Computes temperature = min(255, factoryBaseTemp + factoryTempCoef * tempSensorValue).
// The 4x4 multiply runs as shift-and-add, one sensor bit per clock with the LSB
// first. It is followed by one saturating add cycle. A result is ready exactly
// 5 clocks after start is sampled.
//
// Ports
//   clk              in   1  rising-edge clock
//   rst_n            in   1  asynchronous active-low reset
//   start            in   1  request; sampled only while idle
//   factoryBaseTemp  in   8  unsigned base temperature
//   factoryTempCoef  in   4  unsigned coefficient
//   tempSensorValue  in   4  unsigned raw sensor reading
//   temperature      out  8  registered result, held until the next update
//   busy             out  1  computation in progress
//   done             out  1  one-cycle pulse on the cycle temperature updates
//   overflow         out  1  last result saturated at 255
// -----------------------------------------------------------------------------
module temperature_calculator (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] factoryBaseTemp,
    input  logic [3:0] factoryTempCoef,
    input  logic [3:0] tempSensorValue,
    output logic [7:0] temperature,
    output logic       busy,
    output logic       done,
    output logic       overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ADD  = 2'd2
    } state_t;

    state_t     state_q;

    // Operands are captured at start, so later input changes have no effect.
    logic [7:0] base_q;
    logic [7:0] mcand_q;    // coefficient, shifted left once per MUL cycle
    logic [3:0] mplier_q;   // sensor value, shifted right once per MUL cycle
    logic [7:0] acc_q;      // partial product (15*15 = 225 fits in 8 bits)
    logic [1:0] bit_cnt_q;  // sensor bit currently being processed

    logic [7:0] temp_q;
    logic       ovf_q;
    logic       busy_q;
    logic       done_q;

    logic [7:0] acc_d;
    logic [8:0] sum_d;

    // The LSB of the shifted sensor value selects whether the shifted
    // coefficient is added on this cycle.
    assign acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    // The sum uses 9 bits. Bit 8 set means the result exceeds 255.
    assign sum_d = {1'b0, base_q} + {1'b0, acc_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            base_q    <= 8'd0;
            mcand_q   <= 8'd0;
            mplier_q  <= 4'd0;
            acc_q     <= 8'd0;
            bit_cnt_q <= 2'd0;
            temp_q    <= 8'd0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        base_q    <= factoryBaseTemp;
                        mcand_q   <= {4'd0, factoryTempCoef};
                        mplier_q  <= tempSensorValue;
                        acc_q     <= 8'd0;
                        bit_cnt_q <= 2'd0;
                        busy_q    <= 1'b1;
                        state_q   <= MUL;
                    end
                end
                MUL: begin
                    acc_q     <= acc_d;
                    mcand_q   <= {mcand_q[6:0], 1'b0};
                    mplier_q  <= {1'b0, mplier_q[3:1]};
                    bit_cnt_q <= bit_cnt_q + 2'd1;
                    if (bit_cnt_q == 2'd3) begin
                        state_q <= ADD;
                    end
                end
                ADD: begin
                    temp_q  <= sum_d[8] ? 8'hFF : sum_d[7:0];
                    ovf_q   <= sum_d[8];
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign temperature = temp_q;
    assign overflow    = ovf_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_temperature_calculator.sv
// -----------------------------------------------------------------------------
// tb_temperature_calculator
//
// Checks the calculator against an arithmetic reference: min(255, b + c*s).
// Each cycle of every computation is checked for busy, done and held outputs.
// The run covers directed corner cases, reset during a computation, and
// random traffic. Some random operations hold start high while busy, and some
// run back to back.
// -----------------------------------------------------------------------------
module tb_temperature_calculator;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] factoryBaseTemp;
    logic [3:0] factoryTempCoef;
    logic [3:0] tempSensorValue;
    logic [7:0] temperature;
    logic       busy;
    logic       done;
    logic       overflow;

    int n_chk;
    int n_fail;
    int prev_t;
    int prev_o;

    temperature_calculator dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .factoryBaseTemp (factoryBaseTemp),
        .factoryTempCoef (factoryTempCoef),
        .tempSensorValue (tempSensorValue),
        .temperature     (temperature),
        .busy            (busy),
        .done            (done),
        .overflow        (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference result
    function automatic int ref_temp(input int b, input int c, input int s);
        int sum;
        sum = b + c * s;
        return (sum > 255) ? 255 : sum;
    endfunction

    function automatic int ref_ovf(input int b, input int c, input int s);
        return ((b + c * s) > 255) ? 1 : 0;
    endfunction

    // Called at a negedge. Returns at the negedge that follows the done edge.
    // The caller may then raise start at once for a back-to-back operation.
    task automatic run_op(input int b, input int c, input int s,
                          input bit hold, input int ab, input int ac, input int as_);
        int et;
        int eo;
        factoryBaseTemp = b[7:0];
        factoryTempCoef = c[3:0];
        tempSensorValue = s[3:0];
        start           = 1'b1;
        @(posedge clk);                       // E0: operands sampled
        #1;
        if (!hold) start = 1'b0;
        factoryBaseTemp = ab[7:0];            // changes must not disturb the run
        factoryTempCoef = ac[3:0];
        tempSensorValue = as_[3:0];
        // One check after E0, then one after each of E1..E4
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("busy_run", busy, 1);
            chk("done_early", done, 0);
            chk("temp_hold", temperature, prev_t);
            chk("ovf_hold", overflow, prev_o);
        end
        @(negedge clk);                       // after E5
        et = ref_temp(b, c, s);
        eo = ref_ovf(b, c, s);
        chk("done_pulse", done, 1);
        chk("busy_end", busy, 0);
        chk("temperature", temperature, et);
        chk("overflow", overflow, eo);
        start  = 1'b0;
        prev_t = et;
        prev_o = eo;
    endtask

    // Idle cycles: nothing must move, and done must have fallen.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_done", done, 0);
            chk("idle_busy", busy, 0);
            chk("idle_temp", temperature, prev_t);
            chk("idle_ovf", overflow, prev_o);
        end
    endtask

    initial begin
        int b;
        int c;
        int s;
        n_chk           = 0;
        n_fail          = 0;
        prev_t          = 0;
        prev_o          = 0;
        rst_n           = 1'b0;
        start           = 1'b0;
        factoryBaseTemp = 8'd0;
        factoryTempCoef = 4'd0;
        tempSensorValue = 4'd0;

        #1;
        chk("rst_temp", temperature, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", overflow, 0);

        @(negedge clk);
        rst_n = 1'b1;
        // The first start after reset release is accepted on the next edge.
        run_op(0, 1, 2, 1'b0, 99, 9, 9);
        run_op(17, 8, 2, 1'b0, 0, 0, 0);
        idle(1);
        run_op(255, 15, 15, 1'b0, 1, 1, 1);
        run_op(30, 15, 15, 1'b0, 200, 15, 15);   // sum exactly 255
        run_op(0, 0, 0, 1'b0, 255, 15, 15);
        idle(2);
        run_op(10, 3, 4, 1'b1, 0, 1, 1);         // start held while busy
        idle(2);

        // Reset part-way through the multiply
        factoryBaseTemp = 8'd100;
        factoryTempCoef = 4'd7;
        tempSensorValue = 4'd9;
        start           = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_temp", temperature, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_ovf", overflow, 0);
        prev_t = 0;
        prev_o = 0;
        idle(6);
        rst_n = 1'b1;
        run_op(100, 7, 9, 1'b0, 0, 0, 0);

        // Random traffic
        for (int k = 0; k < 40; k++) begin
            b = int'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) b = int'($urandom_range(200, 255));
            c = int'($urandom_range(0, 15));
            s = int'($urandom_range(0, 15));
            run_op(b, c, s, ($urandom_range(0, 3) == 0),
                   int'($urandom_range(0, 255)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 15)));
            idle(int'($urandom_range(0, 2)));
        end
        idle(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/temperature_calculator.md
TEMPERATURE_CALCULATOR -- requirements
Module: temperature_calculator

Interface
REQ-001 Parameters: none; all widths fixed as listed.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request pulse; operands sampled on the edge where start=1 and block is idle.
REQ-005 factoryBaseTemp  input  8  unsigned factory base temperature.
REQ-006 factoryTempCoef  input  4  unsigned temperature coefficient.
REQ-007 tempSensorValue  input  4  unsigned raw sensor reading.
REQ-008 temperature  output  8  registered result; held between computations.
REQ-009 busy  output  1  high while a computation is in progress.
REQ-010 done  output  1  one-cycle pulse when temperature is updated.
REQ-011 overflow  output  1  registered; set when the last result saturated.

Function
REQ-012 Result SHALL be temperature = min(255, factoryBaseTemp + factoryTempCoef * tempSensorValue), unsigned.
REQ-013 Product SHALL be computed with 8-bit precision (max 15*15=225, no loss); sum SHALL use 9 bits before saturation.
REQ-014 The multiply SHALL be sequential shift-and-add over the 4 sensor bits, LSB first, one bit per cycle.
REQ-015 States SHALL be IDLE, MUL, ADD.
REQ-016 IDLE: on edge E0 with start=1, capture all three operands into internal registers, clear accumulator, go to MUL, busy=1.
REQ-017 MUL: edges E1..E4 process sensor bits 0..3 (add coef<<i to accumulator when bit i=1); after E4 go to ADD.
REQ-018 ADD: on edge E5 load temperature with saturated sum, load overflow (1 if sum>255 else 0), pulse done=1, busy=0, go to IDLE.
REQ-019 Latency SHALL be exactly 5 clocks from the start-sampling edge to the done edge; done SHALL be high for exactly one cycle.
REQ-020 start while busy=1 SHALL be ignored; no queuing.
REQ-021 Input changes after E0 SHALL NOT affect the running computation.
REQ-022 start sampled in IDLE on the same edge that done falls SHALL begin a new computation (back-to-back throughput: one result per 6 cycles).
REQ-023 temperature and overflow SHALL hold their last values until the next ADD edge.
REQ-024 Sum exactly 255 SHALL give temperature=255 with overflow=0.

Reset
REQ-025 rst_n=0 SHALL immediately, independent of clk, force state=IDLE, temperature=0, busy=0, done=0, overflow=0, and clear internal operand/accumulator registers.
REQ-026 Reset during MUL or ADD SHALL abort the computation; no done pulse and no temperature update follows.
REQ-027 After rst_n rises, first start SHALL be accepted on the next rising edge.

Verification
REQ-028 base=0, coef=1, sensor=2, start pulse -> after 5 clocks temperature=2, done pulse, overflow=0.
REQ-029 base=17 (0x11), coef=8, sensor=2 -> temperature=33 (0x21), overflow=0.
REQ-030 base=255, coef=15, sensor=15 -> temperature=255, overflow=1; then base=30, coef=15, sensor=15 -> 255, overflow=0 (sum exactly 255).
REQ-031 base=0, coef=0, sensor=0 -> temperature=0, done pulse after 5 clocks.
REQ-032 Start computation (10,3,4), reassert start and change inputs to (0,1,1) while busy -> single result 22, only one done pulse.
REQ-033 Assert rst_n=0 mid-MUL -> outputs immediately 0, no done; new start after release -> correct result.
